// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, slave FSM states and response/error helpers for the memory slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // The numeric encoding already orders severity: DECERR > SLVERR > OKAY.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != SIZE_4B) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address (FIXED/INCR/WRAP) and array window decode for one channel.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            MEM_DEPTH = 1024,
  parameter logic [AW-1:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic [AW-1:0] addr,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr,
  output logic          in_range
);

  // One extra bit so a window ending at the top of the address space does not wrap.
  localparam logic [AW:0] LO = {1'b0, BASE_ADDR};
  localparam logic [AW:0] HI = LO + (AW+1)'(4 * MEM_DEPTH);

  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;

  always_comb begin
    incr_addr = addr + AW'(4);
    wrap_mask = ((AW'(len) + AW'(1)) << 2) - AW'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
    in_range = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 32-bit memory slave: independent write (AW/W/B) and read (AR/R) burst engines on one
// word array. Read data is registered, so beat 0 appears one cycle after the AR handshake.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int                        AXI_ID_WIDTH   = 1,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        MEM_DEPTH      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXI_ID_WIDTH-1:0]     axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]                  axi_awlen,
  input  logic [2:0]                  axi_awsize,
  input  logic [1:0]                  axi_awburst,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                        axi_wlast,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  output logic [AXI_ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]                  axi_bresp,
  output logic                        axi_bvalid,
  input  logic                        axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]                  axi_arlen,
  input  logic [2:0]                  axi_arsize,
  input  logic [1:0]                  axi_arburst,
  input  logic                        axi_arvalid,
  output logic                        axi_arready,
  output logic [AXI_ID_WIDTH-1:0]     axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                  axi_rresp,
  output logic                        axi_rlast,
  output logic                        axi_rvalid,
  input  logic                        axi_rready
);

  localparam int AW    = AXI_ADDR_WIDTH;
  localparam int NB    = AXI_DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_DEPTH);

  // Array is never reset: contents survive areset.
  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  wr_state_e               w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0] awid_q, awid_d;
  logic [AW-1:0]           waddr_q, waddr_d;
  logic [7:0]              awlen_q, awlen_d, wcnt_q, wcnt_d;
  logic [1:0]              awburst_q, awburst_d, wacc_q, wacc_d, bresp_q, bresp_d;
  logic                    werr_q, werr_d;
  logic [AW-1:0]           w_next_addr;
  logic                    w_in_range, w_last_beat, mem_we;
  logic [1:0]              w_beat_resp;

  rd_state_e                 r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]   arid_q, arid_d;
  logic [AW-1:0]             rnext_q, rnext_d;
  logic [7:0]                arlen_q, arlen_d, rcnt_q, rcnt_d;
  logic [1:0]                arburst_q, arburst_d, rresp_q, rresp_d;
  logic                      rerr_q, rerr_d, rlast_q, rlast_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      r_idle, r_load, r_in_range;
  logic [AW-1:0]             r_ld_addr, r_next_addr;
  logic [7:0]                r_ld_len;
  logic [1:0]                r_ld_burst;

  function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  assign axi_awready = (w_state_q == W_IDLE);
  assign axi_wready  = (w_state_q == W_DATA);
  assign axi_bvalid  = (w_state_q == W_RESP);
  assign axi_bid     = awid_q;
  assign axi_bresp   = bresp_q;
  assign axi_arready = r_idle;
  assign axi_rvalid  = !r_idle;
  assign axi_rid     = arid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_rlast   = rlast_q;

  axi_burst_addr #(.AW(AW), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_waddr (
    .addr      (waddr_q),
    .len       (awlen_q),
    .burst     (awburst_q),
    .next_addr (w_next_addr),
    .in_range  (w_in_range)
  );

  // Read generator works on the address being loaded into the R register: the AR address
  // while idle, otherwise the precomputed next-beat address.
  assign r_idle     = (r_state_q == R_IDLE);
  assign r_ld_addr  = r_idle ? (axi_araddr & ~AW'(3)) : rnext_q;
  assign r_ld_len   = r_idle ? axi_arlen : arlen_q;
  assign r_ld_burst = r_idle ? axi_arburst : arburst_q;

  axi_burst_addr #(.AW(AW), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) u_raddr (
    .addr      (r_ld_addr),
    .len       (r_ld_len),
    .burst     (r_ld_burst),
    .next_addr (r_next_addr),
    .in_range  (r_in_range)
  );

  always_comb begin
    w_state_d   = w_state_q;
    awid_d      = awid_q;
    waddr_d     = waddr_q;
    awlen_d     = awlen_q;
    awburst_d   = awburst_q;
    werr_d      = werr_q;
    wcnt_d      = wcnt_q;
    wacc_d      = wacc_q;
    bresp_d     = bresp_q;
    mem_we      = 1'b0;
    w_beat_resp = RESP_OKAY;
    w_last_beat = (wcnt_q == awlen_q);
    case (w_state_q)
      W_IDLE: begin
        if (axi_awvalid) begin
          awid_d    = axi_awid;
          waddr_d   = axi_awaddr & ~AW'(3);
          awlen_d   = axi_awlen;
          awburst_d = axi_awburst;
          werr_d    = burst_err(axi_awsize, axi_awburst, axi_awlen);
          wcnt_d    = 8'd0;
          wacc_d    = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_wvalid) begin
          if (werr_q)           w_beat_resp = RESP_SLVERR;
          else if (!w_in_range) w_beat_resp = RESP_DECERR;
          else                  mem_we      = 1'b1;
          // The beat counter, not wlast, ends the burst; a bad wlast only taints the response.
          if (axi_wlast != w_last_beat) w_beat_resp = resp_worst(w_beat_resp, RESP_SLVERR);
          wacc_d  = resp_worst(wacc_q, w_beat_resp);
          waddr_d = w_next_addr;
          wcnt_d  = wcnt_q + 8'd1;
          if (w_last_beat) begin
            bresp_d   = wacc_d;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (axi_bready) begin
          bresp_d   = RESP_OKAY;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    rnext_d   = rnext_q;
    arlen_d   = arlen_q;
    arburst_d = arburst_q;
    rerr_d    = rerr_q;
    rcnt_d    = rcnt_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (axi_arvalid) begin
          arid_d    = axi_arid;
          arlen_d   = axi_arlen;
          arburst_d = axi_arburst;
          rerr_d    = burst_err(axi_arsize, axi_arburst, axi_arlen);
          rcnt_d    = 8'd0;
          rlast_d   = (axi_arlen == 8'd0);
          r_load    = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi_rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            rdata_d   = '0;
            rresp_d   = RESP_OKAY;
            r_state_d = R_IDLE;
          end else begin
            rcnt_d  = rcnt_q + 8'd1;
            rlast_d = ((rcnt_q + 8'd1) == arlen_q);
            r_load  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Array read happens before the edge, so a same-cycle write is not yet visible.
    if (r_load) begin
      rnext_d = r_next_addr;
      if (rerr_d) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else if (!r_in_range) begin
        rdata_d = '0;
        rresp_d = RESP_DECERR;
      end else begin
        rdata_d = mem[word_idx(r_ld_addr)];
        rresp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (axi_wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awburst_q <= '0;
      werr_q    <= 1'b0;
      wcnt_q    <= '0;
      wacc_q    <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      awlen_q   <= awlen_d;
      awburst_q <= awburst_d;
      werr_q    <= werr_d;
      wcnt_q    <= wcnt_d;
      wacc_q    <= wacc_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      rnext_q   <= '0;
      arlen_q   <= '0;
      arburst_q <= '0;
      rerr_q    <= 1'b0;
      rcnt_q    <= '0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      rnext_q   <= rnext_d;
      arlen_q   <= arlen_d;
      arburst_q <= arburst_d;
      rerr_q    <= rerr_d;
      rcnt_q    <= rcnt_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule
